// File: rtl/branch_tracker.sv
// Branch-tracking feedback stage: registered bracket depth plus a loop-return stack of body-start PCs.
// Optional BRANCH_TRACKER_STATS_EN adds a max_level high-water-mark output.
module branch_tracker #(
    parameter int PCWidth     = 16,
    parameter int STACK_DEPTH = 16,
    localparam int SP_W       = $clog2(STACK_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    input  logic               op_close,
    input  logic [PCWidth-1:0] depth_in,
    input  logic               searching,
    input  logic               working_zero,
    input  logic [PCWidth-1:0] pc,
    output logic [PCWidth-1:0] depth_out,
    output logic               jump_valid,
    output logic [PCWidth-1:0] jump_target,
    output logic [SP_W-1:0]    stack_level,
    output logic               overflow,
    output logic               underflow
`ifdef BRANCH_TRACKER_STATS_EN
    ,
    output logic [SP_W-1:0]    max_level
`endif
);

    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam logic [PCWidth-1:0] DEPTH_MAX = '1;

    logic [PCWidth-1:0] stack_mem [STACK_DEPTH];
    logic [PCWidth-1:0] depth_next;
    logic [SP_W-1:0]    level_next;
    logic [IDX_W-1:0]   push_idx;
    logic [IDX_W-1:0]   top_idx;
    logic               stack_full;
    logic               stack_empty;
    logic               stack_act;
    logic               do_push;
    logic               do_pop;
    logic               do_jump;
    logic               push_ovf;
    logic               stack_unf;
    logic               depth_ovf;
    logic               depth_unf;

    assign stack_full  = (stack_level == SP_W'(STACK_DEPTH));
    assign stack_empty = (stack_level == '0);
    assign push_idx    = stack_level[IDX_W-1:0];
    assign top_idx     = push_idx - IDX_W'(1);

    // The stack is frozen while branch_ctrl is scanning for a matching bracket.
    assign stack_act = instr_valid & ~searching;
    assign do_push   = stack_act & ~op_close & ~working_zero & ~stack_full;
    assign push_ovf  = stack_act & ~op_close & ~working_zero & stack_full;
    assign do_jump   = stack_act & op_close & ~working_zero & ~stack_empty;
    assign do_pop    = stack_act & op_close & working_zero & ~stack_empty;
    assign stack_unf = stack_act & op_close & stack_empty;

    always_comb begin
        depth_next = depth_out;
        depth_ovf  = 1'b0;
        depth_unf  = 1'b0;
        if (instr_valid) begin
            if (!op_close) begin
                if (depth_in == DEPTH_MAX) begin
                    depth_next = DEPTH_MAX;
                    depth_ovf  = 1'b1;
                end else begin
                    depth_next = depth_in + PCWidth'(1);
                end
            end else if (depth_in != '0) begin
                depth_next = depth_in - PCWidth'(1);
            end else begin
                depth_next = '0;
                depth_unf  = searching;
            end
        end
    end

    always_comb begin
        level_next = stack_level;
        if (do_push) begin
            level_next = stack_level + SP_W'(1);
        end else if (do_pop) begin
            level_next = stack_level - SP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            depth_out   <= '0;
            jump_valid  <= 1'b0;
            jump_target <= '0;
            stack_level <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_mem[i] <= '0;
            end
        end else begin
            depth_out   <= depth_next;
            stack_level <= level_next;
            jump_valid  <= do_jump;
            if (do_jump) begin
                jump_target <= stack_mem[top_idx];
            end
            // Store the instruction after the CBF so a repeat lands on the loop body.
            if (do_push) begin
                stack_mem[push_idx] <= pc + PCWidth'(1);
            end
            if (depth_ovf || push_ovf) begin
                overflow <= 1'b1;
            end
            if (depth_unf || stack_unf) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef BRANCH_TRACKER_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            max_level <= '0;
        end else if (level_next > max_level) begin
            max_level <= level_next;
        end
    end
`endif

endmodule

// File: tb/tb_branch_tracker.sv
// Self-checking bench for branch_tracker: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_branch_tracker;

    localparam int PCW = 16;
    localparam int SD  = 16;
    localparam int SPW = $clog2(SD) + 1;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           instr_valid = 1'b0;
    logic           op_close = 1'b0;
    logic [PCW-1:0] depth_in = '0;
    logic           searching = 1'b0;
    logic           working_zero = 1'b0;
    logic [PCW-1:0] pc = '0;
    logic [PCW-1:0] depth_out;
    logic           jump_valid;
    logic [PCW-1:0] jump_target;
    logic [SPW-1:0] stack_level;
    logic           overflow;
    logic           underflow;
`ifdef BRANCH_TRACKER_STATS_EN
    logic [SPW-1:0] max_level;
`endif

    always #5 clk = ~clk;

    branch_tracker #(.PCWidth(PCW), .STACK_DEPTH(SD)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .op_close     (op_close),
        .depth_in     (depth_in),
        .searching    (searching),
        .working_zero (working_zero),
        .pc           (pc),
        .depth_out    (depth_out),
        .jump_valid   (jump_valid),
        .jump_target  (jump_target),
        .stack_level  (stack_level),
        .overflow     (overflow),
        .underflow    (underflow)
`ifdef BRANCH_TRACKER_STATS_EN
        ,
        .max_level    (max_level)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit compare_en = 0;

    // Reference model state: plain integers and a queue standing in for the return stack.
    int          m_depth = 0;
    bit          m_jv = 0;
    int          m_jt = 0;
    int          m_stk[$];
    bit          m_ovf = 0;
    bit          m_unf = 0;
    int          m_max = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_depth = 0; m_jv = 0; m_jt = 0; m_ovf = 0; m_unf = 0; m_max = 0;
                m_stk.delete();
            end else begin
                m_jv = 0;
                if (instr_valid) begin
                    if (!op_close) begin
                        if (int'(depth_in) == 65535) begin
                            m_depth = 65535;
                            m_ovf = 1;
                        end else begin
                            m_depth = int'(depth_in) + 1;
                        end
                    end else if (int'(depth_in) > 0) begin
                        m_depth = int'(depth_in) - 1;
                    end else begin
                        m_depth = 0;
                        if (searching) m_unf = 1;
                    end
                    if (!searching) begin
                        if (!op_close && !working_zero) begin
                            if (m_stk.size() < SD) m_stk.push_back((int'(pc) + 1) % 65536);
                            else m_ovf = 1;
                        end else if (op_close) begin
                            if (m_stk.size() == 0) m_unf = 1;
                            else if (!working_zero) begin
                                m_jv = 1;
                                m_jt = m_stk[m_stk.size()-1];
                            end else begin
                                void'(m_stk.pop_back());
                            end
                        end
                    end
                end
                if (m_stk.size() > m_max) m_max = m_stk.size();
            end
        end
    end

    always @(negedge clk) begin
        if (compare_en) begin
            checkOutput("depth_out",   32'(depth_out),   32'(m_depth));
            checkOutput("jump_valid",  32'(jump_valid),  32'(m_jv));
            checkOutput("jump_target", 32'(jump_target), 32'(m_jt));
            checkOutput("stack_level", 32'(stack_level), 32'(m_stk.size()));
            checkOutput("overflow",    32'(overflow),    32'(m_ovf));
            checkOutput("underflow",   32'(underflow),   32'(m_unf));
`ifdef BRANCH_TRACKER_STATS_EN
            checkOutput("max_level",   32'(max_level),   32'(m_max));
`endif
        end
    end

    // Called at a negedge; presents one instruction for one posedge and returns at the next negedge.
    task automatic applyStimulus(input bit iv, input bit oc, input logic [PCW-1:0] din,
                                 input bit srch, input bit wz, input logic [PCW-1:0] p);
        instr_valid  = iv;
        op_close     = oc;
        depth_in     = din;
        searching    = srch;
        working_zero = wz;
        pc           = p;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic doReset();
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        compare_en = 1;
        checkOutput("reset_depth", 32'(depth_out), 32'd0);
        checkOutput("reset_level", 32'(stack_level), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Enter a loop, repeat it, exit it.
        applyStimulus(1, 0, 16'd0, 0, 0, 16'h0010);
        checkOutput("push_level", 32'(stack_level), 32'd1);
        checkOutput("push_depth", 32'(depth_out), 32'd1);
        applyStimulus(1, 1, 16'd1, 0, 0, 16'h0020);
        checkOutput("repeat_jv", 32'(jump_valid), 32'd1);
        checkOutput("repeat_target", 32'(jump_target), 32'h0011);
        checkOutput("repeat_level", 32'(stack_level), 32'd1);
        applyStimulus(1, 1, 16'd1, 0, 1, 16'h0020);
        checkOutput("exit_level", 32'(stack_level), 32'd0);
        checkOutput("exit_jv", 32'(jump_valid), 32'd0);
        checkOutput("exit_target_hold", 32'(jump_target), 32'h0011);

        // Asynchronous reset while a jump pulse is live.
        applyStimulus(1, 0, 16'd0, 0, 0, 16'h0020);
        applyStimulus(1, 0, 16'd1, 0, 0, 16'h0030);
        applyStimulus(1, 1, 16'd2, 0, 0, 16'h0040);
        checkOutput("pre_reset_jv", 32'(jump_valid), 32'd1);
        checkOutput("pre_reset_target", 32'(jump_target), 32'h0031);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_jv", 32'(jump_valid), 32'd0);
        checkOutput("async_target", 32'(jump_target), 32'd0);
        checkOutput("async_level", 32'(stack_level), 32'd0);
        checkOutput("async_depth", 32'(depth_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_level", 32'(stack_level), 32'd0);

        // Bracket search: depth moves, stack untouched.
        applyStimulus(1, 0, 16'd0, 1, 0, 16'h0050);
        checkOutput("search_d1", 32'(depth_out), 32'd1);
        applyStimulus(1, 0, 16'd1, 1, 0, 16'h0051);
        checkOutput("search_d2", 32'(depth_out), 32'd2);
        applyStimulus(1, 1, 16'd2, 1, 0, 16'h0052);
        checkOutput("search_d3", 32'(depth_out), 32'd1);
        applyStimulus(1, 1, 16'd1, 1, 0, 16'h0053);
        checkOutput("search_d4", 32'(depth_out), 32'd0);
        checkOutput("search_level", 32'(stack_level), 32'd0);
        checkOutput("search_jv", 32'(jump_valid), 32'd0);

        // Overflow: one push too many, top must still be the 16th entry.
        doReset();
        for (int i = 0; i <= SD; i++) begin
            applyStimulus(1, 0, 16'd0, 0, 0, 16'(16'h0100 + i));
        end
        checkOutput("full_level", 32'(stack_level), 32'(SD));
        checkOutput("full_overflow", 32'(overflow), 32'd1);
        checkOutput("full_underflow", 32'(underflow), 32'd0);
        applyStimulus(1, 1, 16'd1, 0, 0, 16'h0200);
        checkOutput("full_top", 32'(jump_target), 32'h0110);

        // Depth saturation at all-ones.
        doReset();
        applyStimulus(1, 0, 16'hFFFF, 1, 0, 16'h0000);
        checkOutput("sat_depth", 32'(depth_out), 32'hFFFF);
        checkOutput("sat_overflow", 32'(overflow), 32'd1);

        // Underflow cases.
        doReset();
        applyStimulus(1, 1, 16'd0, 0, 0, 16'h0300);
        checkOutput("empty_jv", 32'(jump_valid), 32'd0);
        checkOutput("empty_underflow", 32'(underflow), 32'd1);
        doReset();
        applyStimulus(1, 1, 16'd0, 1, 0, 16'h0300);
        checkOutput("search_zero_depth", 32'(depth_out), 32'd0);
        checkOutput("search_zero_unf", 32'(underflow), 32'd1);
        doReset();
        applyStimulus(1, 1, 16'd0, 0, 1, 16'h0300);
        checkOutput("nosearch_pop_unf", 32'(underflow), 32'd1);

`ifdef BRANCH_TRACKER_STATS_EN
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 16'd0, 0, 0, 16'(i));
        for (int i = 0; i < 2; i++) applyStimulus(1, 1, 16'd1, 0, 1, 16'h0);
        applyStimulus(1, 0, 16'd0, 0, 0, 16'h0007);
        checkOutput("stats_max", 32'(max_level), 32'd3);
        checkOutput("stats_level", 32'(stack_level), 32'd2);
`endif

        // Randomized traffic, with occasional mid-stream resets.
        doReset();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                instr_valid = 1'b0;
                doReset();
            end else begin
                instr_valid  = ($urandom_range(0, 9) < 7);
                op_close     = $urandom_range(0, 1);
                searching    = ($urandom_range(0, 3) == 0);
                working_zero = ($urandom_range(0, 9) < 4);
                pc           = 16'($urandom);
                case ($urandom_range(0, 7))
                    0:       depth_in = 16'h0000;
                    1:       depth_in = 16'hFFFF;
                    2:       depth_in = 16'hFFFE;
                    3:       depth_in = 16'($urandom);
                    default: depth_in = 16'(m_depth);
                endcase
                @(negedge clk);
            end
        end
        instr_valid = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
